// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: lamp input, error clear and all monitor outputs
// master drives light/err_clr and observes; slave is the monitor itself
interface traffic_light_monitor_if;
  logic [0:2] light;
  logic       err_clr;
  logic [1:0] phase;
  logic       locked;
  logic       code_err;
  logic       seq_err;
  logic       stall_err;
  logic       err_sticky;
  logic [7:0] cycle_count;
  modport master (output light, err_clr,
                  input  phase, locked, code_err, seq_err, stall_err, err_sticky, cycle_count);
  modport slave  (input  light, err_clr,
                  output phase, locked, code_err, seq_err, stall_err, err_sticky, cycle_count);
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: tracks a G->Y->R lamp sequence, flags illegal codes, order and dwell errors
// clock/reset: single clock, synchronous active-high reset
// bus.light/err_clr in; bus.phase/locked/code_err/seq_err/stall_err/err_sticky/cycle_count out (all registered)
module traffic_light_monitor #(
  parameter int unsigned MAX_DWELL = 1
) (
  input logic clock,
  input logic reset,
  traffic_light_monitor_if.slave bus
);
  typedef enum logic [1:0] {HUNT, GOT_G, GOT_Y, GOT_R} state_t;
  localparam logic [7:0] MAX = 8'(MAX_DWELL);
  state_t state, state_n, obs, succ;
  logic [7:0] dwell, dwell_n, count, count_n;
  logic code_err, seq_err, stall_err, sticky;
  logic code_n, seq_n, stall_n;
  // state encoding doubles as the phase output
  assign bus.phase = state;
  assign bus.locked = state != HUNT;
  assign bus.code_err = code_err;
  assign bus.seq_err = seq_err;
  assign bus.stall_err = stall_err;
  assign bus.err_sticky = sticky;
  assign bus.cycle_count = count;
  always_comb begin
    obs = bus.light == 3'b010 ? GOT_G : bus.light == 3'b001 ? GOT_Y : bus.light == 3'b100 ? GOT_R : HUNT;
    succ = state == GOT_G ? GOT_Y : state == GOT_Y ? GOT_R : GOT_G;
    state_n = obs;
    dwell_n = 8'd1;
    count_n = count;
    code_n = 1'b0;
    seq_n = 1'b0;
    stall_n = 1'b0;
    if (obs == HUNT) begin
      code_n = 1'b1;
      dwell_n = 8'd0;
    end else if (state == HUNT) begin
      dwell_n = 8'd1;
    end else if (obs == state) begin
      stall_n = dwell == MAX;
      dwell_n = stall_n ? dwell : dwell + 8'd1;
    end else if (obs == succ) begin
      count_n = state == GOT_R && count != 8'hff ? count + 8'd1 : count;
    end else begin
      seq_n = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HUNT;
      dwell <= 8'd0;
      count <= 8'd0;
      code_err <= 1'b0;
      seq_err <= 1'b0;
      stall_err <= 1'b0;
      sticky <= 1'b0;
    end else begin
      state <= state_n;
      dwell <= dwell_n;
      count <= count_n;
      code_err <= code_n;
      seq_err <= seq_n;
      stall_err <= stall_n;
      // a new error outranks a simultaneous clear
      sticky <= code_n | seq_n | stall_n | (sticky & ~bus.err_clr);
    end
  end
endmodule
